// File: rtl/vend_change_dispenser.sv
// Change dispenser: takes the committed credit, computes the excess over
// PRICE and pays it out largest coin first as timed eject pulses on the
// coin-hopper solenoids. Outputs are registered from the state flops, so
// every output trails the state that produces it by one cycle.
module vend_change_dispenser #(
  parameter int PRICE        = 9,
  parameter int CREDIT_W     = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CREDIT_W-1:0] credit,
  output logic                coin_q,
  output logic                coin_d,
  output logic                coin_n,
  output logic                busy,
  output logic                done,
  output logic                underpay,
  output logic [3:0]          coin_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_PULSE  = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    C_QTR  = 2'd0,
    C_DIME = 2'd1,
    C_NICK = 2'd2
  } coin_t;

  localparam logic [CREDIT_W-1:0] QTR_VAL  = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] DIME_VAL = CREDIT_W'(2);
  localparam logic [CREDIT_W-1:0] NICK_VAL = CREDIT_W'(1);
  localparam logic [7:0]          PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0]          GAP_LAST   = 8'(GAP_CYCLES - 1);

  // Coin counter stops at all-ones rather than wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Change owed in nickels; an underpayment owes nothing (no wrap).
  function automatic logic [CREDIT_W-1:0] change_of(input logic [CREDIT_W-1:0] cr);
    logic [31:0] cr_ext;
    cr_ext = 32'(cr);
    return (cr_ext >= 32'(PRICE)) ? CREDIT_W'(cr_ext - 32'(PRICE)) : '0;
  endfunction

  state_t              state_q, state_d;
  coin_t               sel_q, sel_d;
  logic [CREDIT_W-1:0] rem_q, rem_d;
  logic [7:0]          tmr_q, tmr_d;
  logic                upr_q, upr_d;
  logic [3:0]          count_q, count_d;
  logic                qtr_q, qtr_d;
  logic                dime_q, dime_d;
  logic                nick_q, nick_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                underpay_q, underpay_d;

  // Next-state, coin selection and Moore output decode from current state.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rem_d      = rem_q;
    tmr_d      = tmr_q;
    upr_d      = upr_q;
    count_d    = count_q;

    qtr_d      = (state_q == S_PULSE) && (sel_q == C_QTR);
    dime_d     = (state_q == S_PULSE) && (sel_q == C_DIME);
    nick_d     = (state_q == S_PULSE) && (sel_q == C_NICK);
    busy_d     = (state_q == S_SELECT) || (state_q == S_PULSE) || (state_q == S_GAP);
    done_d     = (state_q == S_DONE);
    underpay_d = (state_q == S_DONE) && upr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = change_of(credit);
          upr_d   = (32'(credit) < 32'(PRICE));
          count_d = 4'd0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          if (rem_q >= QTR_VAL) begin
            sel_d = C_QTR;
            rem_d = rem_q - QTR_VAL;
          end else if (rem_q >= DIME_VAL) begin
            sel_d = C_DIME;
            rem_d = rem_q - DIME_VAL;
          end else begin
            sel_d = C_NICK;
            rem_d = rem_q - NICK_VAL;
          end
          count_d = sat_inc(count_q);
          tmr_d   = 8'd0;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        if (tmr_q == PULSE_LAST) begin
          tmr_d   = 8'd0;
          state_d = S_GAP;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      S_GAP: begin
        if (tmr_q == GAP_LAST) begin
          tmr_d   = 8'd0;
          state_d = S_SELECT;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= C_QTR;
      rem_q      <= '0;
      tmr_q      <= 8'd0;
      upr_q      <= 1'b0;
      count_q    <= 4'd0;
      qtr_q      <= 1'b0;
      dime_q     <= 1'b0;
      nick_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underpay_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rem_q      <= rem_d;
      tmr_q      <= tmr_d;
      upr_q      <= upr_d;
      count_q    <= count_d;
      qtr_q      <= qtr_d;
      dime_q     <= dime_d;
      nick_q     <= nick_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underpay_q <= underpay_d;
    end
  end

  assign coin_q     = qtr_q;
  assign coin_d     = dime_q;
  assign coin_n     = nick_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign underpay   = underpay_q;
  assign coin_count = count_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed bench for the change dispenser: default-price instance A and a
// PRICE=3 instance B share clock and reset.
module tb_vend_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic [3:0] credit_a, credit_b;
  logic       cq_a, cd_a, cn_a, busy_a, done_a, up_a;
  logic       cq_b, cd_b, cn_b, busy_b, done_b, up_b;
  logic [3:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] QTR  = 3'b100;
  localparam logic [2:0] DIME = 3'b010;
  localparam logic [2:0] NICK = 3'b001;

  always #5 clk = ~clk;

  vend_change_dispenser u_a (
    .clk(clk), .reset(reset), .start(start_a), .credit(credit_a),
    .coin_q(cq_a), .coin_d(cd_a), .coin_n(cn_a), .busy(busy_a),
    .done(done_a), .underpay(up_a), .coin_count(cnt_a)
  );

  vend_change_dispenser #(.PRICE(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .credit(credit_b),
    .coin_q(cq_b), .coin_d(cd_b), .coin_n(cn_b), .busy(busy_b),
    .done(done_b), .underpay(up_b), .coin_count(cnt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {coin_q, coin_d, coin_n, busy, done} at cycle k after the start edge:
  // coin i is high 2..3 cycles after its slot begins (slots are 6 cycles),
  // busy covers cycles 1..6n+1 and done lands on cycle 6n+2.
  function automatic logic [4:0] exp_vec(input int k, input int nc,
                                         input logic [2:0] c0, input logic [2:0] c1);
    logic [2:0] coin;
    logic       b, d;
    coin = 3'b000;
    if (nc >= 1 && (k == 2 || k == 3)) coin = c0;
    if (nc >= 2 && (k == 8 || k == 9)) coin = c1;
    b = (k >= 1) && (k <= 6 * nc + 1);
    d = (k == 6 * nc + 2);
    return {coin, b, d};
  endfunction

  function automatic logic [4:0] obs_vec(input logic which);
    return which ? {cq_b, cd_b, cn_b, busy_b, done_b}
                 : {cq_a, cd_a, cn_a, busy_a, done_a};
  endfunction

  // One complete transaction on instance A (which=0) or B (which=1).
  task automatic txn(input string tag, input logic which, input logic [3:0] cr,
                     input int nc, input logic [2:0] c0, input logic [2:0] c1,
                     input logic exp_up);
    logic up_obs;
    if (which) begin credit_b = cr; start_b = 1'b1; end
    else       begin credit_a = cr; start_a = 1'b1; end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      up_obs = which ? up_b : up_a;
      check($sformatf("%s_outs_k%0d", tag, k), 8'(obs_vec(which)),
            8'(exp_vec(k, nc, c0, c1)));
      check($sformatf("%s_underpay_k%0d", tag, k), 8'(up_obs),
            8'(exp_up && (k == 6 * nc + 2)));
      if (k < 16) tick();
    end
    check({tag, "_count"}, 8'(which ? cnt_b : cnt_a), 8'(nc));
  endtask

  initial begin
    reset    = 1'b1;
    start_a  = 1'b0;
    start_b  = 1'b0;
    credit_a = 4'd0;
    credit_b = 4'd0;
    tick(); tick(); tick();
    check("reset_outs_a", 8'(obs_vec(1'b0)), 8'd0);
    check("reset_outs_b", 8'(obs_vec(1'b1)), 8'd0);
    check("reset_misc_a", {3'b0, up_a, cnt_a}, 8'd0);
    check("reset_misc_b", {3'b0, up_b, cnt_b}, 8'd0);
    reset = 1'b0;
    tick();

    txn("c13_two_dimes",     1'b0, 4'd13, 2, DIME, DIME, 1'b0);
    txn("c12_dime_nickel",   1'b0, 4'd12, 2, DIME, NICK, 1'b0);
    txn("c9_exact",          1'b0, 4'd9,  0, 3'b000, 3'b000, 1'b0);
    txn("c5_underpay",       1'b0, 4'd5,  0, 3'b000, 3'b000, 1'b1);
    txn("p3_c13_two_quarts", 1'b1, 4'd13, 2, QTR,  QTR,  1'b0);

    // Restart during the first pulse is ignored, then reset mid second pulse.
    credit_a = 4'd13;
    start_a  = 1'b1;
    tick();                      // k=0
    start_a = 1'b0;
    tick(); tick();              // k=2
    check("ign_first_pulse", 8'(cd_a), 8'd1);
    credit_a = 4'd0;
    start_a  = 1'b1;
    tick();                      // k=3
    start_a = 1'b0;
    check("ign_pulse_held", 8'(obs_vec(1'b0)), 8'(exp_vec(3, 2, DIME, DIME)));
    for (int k = 4; k <= 8; k++) tick();
    check("ign_second_dime", 8'(obs_vec(1'b0)), 8'(exp_vec(8, 2, DIME, DIME)));
    check("ign_count_mid", 8'(cnt_a), 8'd2);
    reset = 1'b1;
    tick();                      // k=9, reset edge
    reset = 1'b0;
    check("rst_mid_outs", 8'(obs_vec(1'b0)), 8'd0);
    check("rst_mid_count", 8'(cnt_a), 8'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rst_quiet_%0d", k), {2'b0, obs_vec(1'b0), up_a}, 8'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
